i2c_cfg_sequencer: RTL and testbench

//  Walks a register-write table and drives the I2C write master. For each entry it

---
 rtl/i2c_cfg_sequencer.sv | 130 +++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a register-write table at boot and hands each
// {Addr,SubAddrH,SubAddrL,Data} entry to an I2C write master, one at a time.
// Optional feature macro: I2C_CFG_RETRY_EN (re-send a NACKed or timed-out entry
// up to MAX_RETRY extra times before giving up).
module i2c_cfg_sequencer #(
  parameter int NUM_ENTRIES   = 16,
  parameter int IDX_W         = 4,
  parameter int GAP_CYCLES    = 100,
  parameter int START_TIMEOUT = 16,
  parameter int MAX_RETRY     = 3
) (
  input  logic             I2C_clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [31:0]      tbl_entry,
  output logic [7:0]       Addr,
  output logic [7:0]       SubAddrH,
  output logic [7:0]       SubAddrL,
  output logic [7:0]       Data,
  output logic             write,
  input  logic             ready,
  input  logic             errory,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [IDX_W-1:0] fail_idx
);

  // One counter serves both the start timeout and the inter-transfer gap.
  localparam int CNT_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_END  = CNT_W'(START_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE,
    S_GAP, S_ERR, S_RGAP, S_DONE, S_FAIL
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             launch;   // start accepted from a resting state
  logic             retry_ok; // ERR may go round again instead of failing

`ifdef I2C_CFG_RETRY_EN
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RTY_W-1:0] retry;

  assign retry_ok = (retry < RTY_W'(MAX_RETRY));

  // Attempts made on the current entry; reset whenever a new entry begins.
  always_ff @(posedge I2C_clk or posedge reset) begin
    if (reset)                                retry <= '0;
    else if (launch)                          retry <= '0;
    else if (state == S_GAP && state_n == S_FETCH) retry <= '0;
    else if (state == S_ERR && state_n == S_RGAP)  retry <= retry + 1'b1;
  end
`else
  assign retry_ok = 1'b0;
`endif

  assign launch  = start && (state == S_IDLE || state == S_DONE || state == S_FAIL);
  assign tbl_idx = idx;
  assign busy    = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
  assign done    = (state == S_DONE);
  assign fail    = (state == S_FAIL);

  // State register.
  always_ff @(posedge I2C_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and the single-cycle write strobe.
  always_comb begin
    state_n = state;
    write   = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_FAIL: if (start) state_n = S_FETCH;
      S_FETCH:                state_n = S_ISSUE;
      S_ISSUE: begin
        if (ready) begin
          write   = 1'b1;
          state_n = S_WAIT_BUSY;
        end
      end
      // ready falling is checked first so it beats a simultaneous timeout.
      S_WAIT_BUSY: begin
        if (!ready)             state_n = S_WAIT_DONE;
        else if (cnt == TO_END) state_n = S_ERR;
      end
      S_WAIT_DONE: if (ready) state_n = errory ? S_ERR : S_GAP;
      S_GAP:       if (cnt == GAP_END) state_n = (idx == LAST) ? S_DONE : S_FETCH;
      S_ERR:       state_n = retry_ok ? S_RGAP : S_FAIL;
      S_RGAP:      if (cnt == GAP_END) state_n = S_ISSUE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Cycle counter runs only in timed states and restarts on every state change.
  always_ff @(posedge I2C_clk or posedge reset) begin
    if (reset)                                   cnt <= '0;
    else if (state_n != state)                   cnt <= '0;
    else if (state == S_WAIT_BUSY || state == S_GAP || state == S_RGAP)
                                                 cnt <= cnt + 1'b1;
  end

  // Table index: back to 0 on launch, advance after a good entry's gap.
  always_ff @(posedge I2C_clk or posedge reset) begin
    if (reset)                                     idx <= '0;
    else if (launch)                               idx <= '0;
    else if (state == S_GAP && state_n == S_FETCH) idx <= idx + 1'b1;
  end

  // Master payload is loaded only in FETCH, so it stays put for the whole transfer.
  always_ff @(posedge I2C_clk or posedge reset) begin
    if (reset)                 {Addr, SubAddrH, SubAddrL, Data} <= '0;
    else if (state == S_FETCH) {Addr, SubAddrH, SubAddrL, Data} <= tbl_entry;
  end

  // Capture which entry gave up.
  always_ff @(posedge I2C_clk or posedge reset) begin
    if (reset)                                    fail_idx <= '0;
    else if (state == S_ERR && state_n == S_FAIL) fail_idx <= idx;
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: random ROM contents and NACK plans, a
// behavioural I2C master, and a reference model that lists the expected
// write attempts and final outcome from the table-walk rules.
module tb_i2c_cfg_sequencer;
  localparam int NE = 3, IW = 2, GAP = 4, TO = 16, MR = 3;
`ifdef I2C_CFG_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic          I2C_clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] tbl_idx;
  logic [31:0]   tbl_entry;
  logic [7:0]    Addr, SubAddrH, SubAddrL, Data;
  logic          write;
  logic          ready = 1'b1;
  logic          errory = 1'b0;
  logic          busy, done, fail;
  logic [IW-1:0] fail_idx;

  i2c_cfg_sequencer #(.NUM_ENTRIES(NE), .IDX_W(IW), .GAP_CYCLES(GAP),
                      .START_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .I2C_clk(I2C_clk), .reset(reset), .start(start), .tbl_idx(tbl_idx),
    .tbl_entry(tbl_entry), .Addr(Addr), .SubAddrH(SubAddrH), .SubAddrL(SubAddrL),
    .Data(Data), .write(write), .ready(ready), .errory(errory), .busy(busy),
    .done(done), .fail(fail), .fail_idx(fail_idx));

  always #5 I2C_clk = ~I2C_clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge I2C_clk) cyc <= cyc + 1;

  logic [31:0] rom [NE];
  assign tbl_entry = (tbl_idx < IW'(NE)) ? rom[tbl_idx] : 32'hDEAD_BEEF;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected attempt list (entry, nacked?) and outcome.
  int nacks [NE];
  int exp_ent[$];
  bit exp_nack[$];
  bit exp_done;
  int exp_fidx;

  task automatic build_expect();
    exp_ent.delete(); exp_nack.delete();
    exp_done = 1'b1; exp_fidx = 0;
    for (int e = 0; e < NE && exp_done; e++) begin
      for (int a = 0; a <= MR; a++) begin
        bit n;
        n = (a < nacks[e]);
        exp_ent.push_back(e);
        exp_nack.push_back(n);
        if (!n) break;
        if (!RETRY_EN || a == MR) begin
          exp_done = 1'b0; exp_fidx = e; break;
        end
      end
    end
  endtask

  // Behavioural master: logs each write pulse, drops ready after 1-3 cycles,
  // holds it low 1-6 cycles, then raises it with the planned errory.
  logic [31:0] log_pl[$];
  int          log_cyc[$];
  int          m_phase = 0, m_cnt = 0;
  bit          m_err = 1'b0, stuck = 1'b0;

  always @(negedge I2C_clk) begin
    if (reset) begin
      m_phase = 0; ready = 1'b1; errory = 1'b0;
    end else begin
      case (m_phase)
        0: if (write) begin
          log_pl.push_back({Addr, SubAddrH, SubAddrL, Data});
          log_cyc.push_back(cyc);
          m_err = (log_pl.size() <= exp_nack.size()) ? exp_nack[log_pl.size()-1] : 1'b0;
          if (!stuck) begin m_phase = 1; m_cnt = $urandom_range(1, 3); end
        end
        1: begin
          chk("write_in_xfer", write, 0);
          m_cnt--;
          if (m_cnt == 0) begin
            ready = 1'b0; errory = 1'($urandom); m_phase = 2; m_cnt = $urandom_range(1, 6);
          end
        end
        default: begin
          chk("write_in_xfer", write, 0);
          chk("payload_stable", {Addr, SubAddrH, SubAddrL, Data}, log_pl[$]);
          m_cnt--;
          if (m_cnt == 0) begin ready = 1'b1; errory = m_err; m_phase = 0; end
        end
      endcase
    end
  end

  task automatic check_reset_outs(string tag);
    chk({tag, "_idx"}, tbl_idx, 0);
    chk({tag, "_payload"}, {Addr, SubAddrH, SubAddrL, Data}, 0);
    chk({tag, "_ctl"}, {write, busy, done, fail}, 0);
    chk({tag, "_fidx"}, fail_idx, 0);
  endtask

  task automatic run(string tag, bit noise);
    int it, s_cyc, n;
    build_expect();
    log_pl.delete(); log_cyc.delete();
    @(negedge I2C_clk); start = 1'b1; s_cyc = cyc;
    @(negedge I2C_clk); start = 1'b0;
    it = 0;
    while (!(done || fail) && it < 3000) begin
      if (noise && it == 12) begin
        chk({tag, "_busy_mid"}, busy, 1);
        start = 1'b1;
      end else start = 1'b0;
      @(negedge I2C_clk); it++;
    end
    start = 1'b0;
    chk({tag, "_finished"}, it < 3000, 1);
    chk({tag, "_pulses"}, log_pl.size(), exp_ent.size());
    n = (log_pl.size() < exp_ent.size()) ? log_pl.size() : exp_ent.size();
    for (int k = 0; k < n; k++) chk({tag, "_payload"}, log_pl[k], rom[exp_ent[k]]);
    if (log_cyc.size() > 0) chk({tag, "_latency"}, log_cyc[0] - s_cyc, 2);
    for (int k = 1; k < log_cyc.size(); k++)
      chk({tag, "_gap"}, (log_cyc[k] - log_cyc[k-1]) > GAP, 1);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_fail"}, fail, !exp_done);
    chk({tag, "_busy"}, busy, 0);
    if (!exp_done) chk({tag, "_fidx"}, fail_idx, exp_fidx);
    repeat (3) @(negedge I2C_clk);
  endtask

  task automatic rand_rom();
    for (int e = 0; e < NE; e++) rom[e] = $urandom;
  endtask

  initial begin
    int it, d, expp;
    rand_rom();
    for (int e = 0; e < NE; e++) nacks[e] = 0;
    repeat (3) @(negedge I2C_clk);
    check_reset_outs("reset");
    reset = 1'b0;
    repeat (2) @(negedge I2C_clk);

    nacks = '{0, 0, 0}; run("all_ack", 1'b0);
    nacks = '{0, 1, 0}; run("nack1", 1'b0);
    nacks = '{0, 2, 0}; run("nack1x2", 1'b0);
    nacks = '{99, 0, 0}; run("nack0_always", 1'b0);
    for (int r = 0; r < 4; r++) begin
      rand_rom();
      for (int e = 0; e < NE; e++) nacks[e] = $urandom_range(0, 1) ? 0 : $urandom_range(1, 4);
      run("random", 1'b0);
    end
    rand_rom();
    nacks = '{0, 0, 0}; run("start_while_busy", 1'b1);

    // Master never drops ready: every attempt times out.
    stuck = 1'b1;
    exp_ent.delete(); exp_nack.delete(); log_pl.delete(); log_cyc.delete();
    @(negedge I2C_clk); start = 1'b1;
    @(negedge I2C_clk); start = 1'b0;
    it = 0;
    while (!fail && it < 400) begin @(negedge I2C_clk); it++; end
    expp = RETRY_EN ? MR + 1 : 1;
    chk("timeout_fail", fail, 1);
    chk("timeout_pulses", log_pl.size(), expp);
    chk("timeout_fidx", fail_idx, 0);
    d = (log_cyc.size() > 0) ? cyc - log_cyc[$] : 0;
    chk("timeout_latency", (d >= 16 && d <= 19), 1);
    stuck = 1'b0;
    repeat (2) @(negedge I2C_clk);

    // Reset in the middle of a transfer, then a clean restart from entry 0.
    rand_rom();
    nacks = '{0, 0, 0};
    build_expect();
    @(negedge I2C_clk); start = 1'b1;
    @(negedge I2C_clk); start = 1'b0;
    it = 0;
    while (m_phase != 2 && it < 200) begin @(negedge I2C_clk); it++; end
    chk("mid_reached_wait_done", m_phase, 2);
    reset = 1'b1;
    #1 check_reset_outs("mid_reset");
    repeat (3) @(negedge I2C_clk);
    reset = 1'b0;
    @(negedge I2C_clk);
    run("after_reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
